// File: rtl/flow_ctrl_pkg.sv
// Shared flow-control definitions for the leaf-interface egress path:
// packet layout, arbitration mode encodings and width helpers.
package flow_ctrl_pkg;

  localparam int PKT_VLD_BIT = 96;
  localparam int ARB_RR      = 0;
  localparam int ARB_FIXED   = 1;

  // Index width that stays at least one bit wide for single-entry vectors
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Request arbiter with a one-hot combinational grant; round-robin from an internal
// pointer, or fixed lowest-index priority when FIXED_PRIO is set.
module rr_arbiter
  import flow_ctrl_pkg::*;
#(
  parameter int N          = 7,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PTR_W = clog2_min1(N);

  logic [PTR_W-1:0] ptr_r;
  logic [PTR_W-1:0] win_s;
  logic             found_s;
  int               idx_s;

  // Scan requesters starting at the pointer (or at 0 in fixed mode); first hit wins
  always_comb begin
    gnt     = '0;
    win_s   = '0;
    found_s = 1'b0;
    idx_s   = 0;
    for (int k = 0; k < N; k++) begin
      idx_s = (FIXED_PRIO ? 0 : int'(ptr_r)) + k;
      if (idx_s >= N) begin
        idx_s = idx_s - N;
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && req[idx_s]) begin
        gnt[idx_s] = 1'b1;
        win_s      = idx_s[PTR_W-1:0];
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer moves past the winner only when the grant is actually taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (advance && found_s) begin
      ptr_r <= (int'(win_s) == N - 1) ? '0 : win_s + PTR_W'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/stream_egress_arbiter.sv
// Egress stage: merges freespace updates (strict priority) and credit-gated data ports
// onto one registered stream, with a replay path for downstream rejects.
module stream_egress_arbiter
  import flow_ctrl_pkg::*;
#(
  parameter int PACKET_BITS   = 97,
  parameter int NUM_IN_PORTS  = 7,
  parameter int NUM_OUT_PORTS = 7,
  parameter int CREDIT_BITS   = 8,
  parameter int INIT_CREDIT   = 64,
  parameter int ARB_MODE      = 0
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   ap_start,
  input  logic                                   resend,
  input  logic [PACKET_BITS*NUM_OUT_PORTS-1:0]   pkt_out_ports,
  input  logic [NUM_OUT_PORTS-1:0]               empty,
  output logic [NUM_OUT_PORTS-1:0]               rd_en_sel,
  input  logic [NUM_IN_PORTS-1:0]                fs_req,
  input  logic [PACKET_BITS*NUM_IN_PORTS-1:0]    fs_pkt,
  output logic [NUM_IN_PORTS-1:0]                fs_ack,
  input  logic                                   credit_vld,
  input  logic [clog2_min1(NUM_OUT_PORTS)-1:0]   credit_port,
  input  logic [CREDIT_BITS-1:0]                 credit_amt,
  output logic [PACKET_BITS-1:0]                 stream_out,
  output logic [NUM_OUT_PORTS-1:0]               credit_zero
);

  localparam logic [CREDIT_BITS-1:0] CREDIT_MAX  = '1;
  localparam logic [CREDIT_BITS-1:0] CREDIT_INIT = CREDIT_BITS'(INIT_CREDIT);

  logic [CREDIT_BITS-1:0]   credit_r     [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]   credit_nxt_s [NUM_OUT_PORTS];
  logic [CREDIT_BITS:0]     credit_sum_s [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] credit_zero_r;
  logic [NUM_OUT_PORTS-1:0] data_req_s;
  logic [NUM_OUT_PORTS-1:0] data_gnt_s;
  logic [NUM_IN_PORTS-1:0]  fs_gnt_s;
  logic                     fs_go_s;
  logic                     data_go_s;
  logic [PACKET_BITS-1:0]   sel_pkt_s;
  logic [PACKET_BITS-1:0]   stream_out_r;
  logic [PACKET_BITS-1:0]   last_pkt_r;

  // Data ports compete only with a packet waiting, credit left and the stage started
  always_comb begin
    data_req_s = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      data_req_s[i] = !empty[i] && (credit_r[i] != '0) && ap_start;
    end
  end

  // Freespace outranks data so credit updates can never be starved behind data
  assign fs_go_s   = reset && !resend;
  assign data_go_s = reset && !resend && !(|fs_req);

  rr_arbiter #(
    .N          (NUM_IN_PORTS),
    .FIXED_PRIO (1'b0)
  ) u_fs_arb (
    .clk     (clk),
    .rst_n   (reset),
    .req     (fs_req),
    .advance (fs_go_s),
    .gnt     (fs_gnt_s)
  );

  rr_arbiter #(
    .N          (NUM_OUT_PORTS),
    .FIXED_PRIO (ARB_MODE == ARB_FIXED)
  ) u_data_arb (
    .clk     (clk),
    .rst_n   (reset),
    .req     (data_req_s),
    .advance (data_go_s),
    .gnt     (data_gnt_s)
  );

  assign fs_ack    = fs_gnt_s & {NUM_IN_PORTS{fs_go_s}};
  assign rd_en_sel = data_gnt_s & {NUM_OUT_PORTS{data_go_s}};

  // At most one grant is live, so an AND-OR mux selects the packet to register
  always_comb begin
    sel_pkt_s = '0;
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      sel_pkt_s = sel_pkt_s | ({PACKET_BITS{fs_ack[i]}} & fs_pkt[i*PACKET_BITS +: PACKET_BITS]);
    end
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      sel_pkt_s = sel_pkt_s | ({PACKET_BITS{rd_en_sel[i]}} & pkt_out_ports[i*PACKET_BITS +: PACKET_BITS]);
    end
  end

  // Output register plus the copy replayed while downstream asks for a resend
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stream_out_r <= '0;
      last_pkt_r   <= '0;
    end else if (resend) begin
      stream_out_r <= last_pkt_r;
      last_pkt_r   <= last_pkt_r;
    end else begin
      stream_out_r <= sel_pkt_s;
      last_pkt_r   <= (|sel_pkt_s) ? sel_pkt_s : last_pkt_r;
    end
  end

  // Next credit: returns add, a grant takes one, result clamps at the counter maximum
  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      credit_sum_s[i] = {1'b0, credit_r[i]}
                      + ((credit_vld && (int'(credit_port) == i)) ? {1'b0, credit_amt} : '0)
                      - {{CREDIT_BITS{1'b0}}, rd_en_sel[i]};
      if (credit_sum_s[i] > {1'b0, CREDIT_MAX}) begin
        credit_nxt_s[i] = CREDIT_MAX;
      end else begin
        credit_nxt_s[i] = credit_sum_s[i][CREDIT_BITS-1:0];
      end
    end
  end

  // Credit counters and their registered zero flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit_r[i] <= CREDIT_INIT;
      end
      credit_zero_r <= '0;
    end else begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit_r[i]      <= credit_nxt_s[i];
        credit_zero_r[i] <= (credit_r[i] == '0);
      end
    end
  end

  assign stream_out  = stream_out_r;
  assign credit_zero = credit_zero_r;

endmodule
